// File: rtl/uart_alu_ctrl.sv
// Command sequencer between the UART RX and TX FIFOs: pops operand A, operand B
// and an opcode byte, evaluates them on a small ALU and pushes the result byte.
module uart_alu_ctrl #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_r_data,
    output logic               o_rd_uart,
    input  logic               i_tx_full,
    output logic               o_wr_uart,
    output logic [NB_DATA-1:0] o_w_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_op_err
);

    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND} state_t;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(8'h20);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(8'h22);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(8'h24);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(8'h25);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(8'h26);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(8'h27);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(8'h03);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(8'h02);

    state_t             state;
    logic [NB_DATA-1:0] a;
    logic [NB_DATA-1:0] b;
    logic [NB_OP-1:0]   op;
    logic [NB_DATA-1:0] result;
    logic               op_err;
    logic [NB_DATA-1:0] alu_result;
    logic               alu_err;
    logic               in_rx_state;

    // Shifts by NB_DATA or more fall out naturally: >> fills with zeros and
    // >>> on a signed operand fills with copies of the sign bit.
    always_comb begin
        alu_result = '0;
        alu_err    = 1'b0;
        case (op)
            OP_ADD:  alu_result = a + b;
            OP_SUB:  alu_result = a - b;
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_XOR:  alu_result = a ^ b;
            OP_NOR:  alu_result = ~(a | b);
            OP_SRA:  alu_result = $signed(a) >>> b;
            OP_SRL:  alu_result = a >> b;
            default: alu_err    = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state  <= WAIT_A;
            a      <= '0;
            b      <= '0;
            op     <= '0;
            result <= '0;
            op_err <= 1'b0;
        end else begin
            case (state)
                WAIT_A: begin
                    if (!i_rx_empty) begin
                        a     <= i_r_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (!i_rx_empty) begin
                        b     <= i_r_data;
                        state <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (!i_rx_empty) begin
                        op    <= i_r_data[NB_OP-1:0];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    result <= alu_result;
                    op_err <= alu_err;
                    state  <= SEND;
                end
                SEND: begin
                    if (!i_tx_full) begin
                        state <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

    // Strobes are gated by reset so the FIFOs are never touched while held in reset.
    assign in_rx_state = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);
    assign o_rd_uart   = reset && in_rx_state && !i_rx_empty;
    assign o_wr_uart   = reset && (state == SEND) && !i_tx_full;
    assign o_w_data    = result;
    assign o_result    = result;
    assign o_op_err    = op_err;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: an RX byte source, a TX push monitor and a queue of
// expected {op_err, data} results built from an independent ALU model.
module tb_uart_alu_ctrl;

    logic       i_clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_rx_empty = 1'b1;
    logic [7:0] i_r_data = 8'h00;
    logic       i_tx_full = 1'b0;
    logic       o_rd_uart;
    logic       o_wr_uart;
    logic [7:0] o_w_data;
    logic [7:0] o_result;
    logic       o_op_err;

    logic [7:0] rx_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         pop_cycle[$];
    int         push_cycle[$];
    int         rx_rd = 0;
    int         obs_rd = 0;
    int         pop_total = 0;
    int         pops_seen = 0;
    int         cycle = 0;
    int         illegal_pop = 0;
    int         illegal_push = 0;
    bit         gap_en = 1'b0;
    bit         fake_rx = 1'b0;
    int         checks = 0;
    int         fails = 0;

    uart_alu_ctrl #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk      (i_clk),
        .reset      (reset),
        .i_rx_empty (i_rx_empty),
        .i_r_data   (i_r_data),
        .o_rd_uart  (o_rd_uart),
        .i_tx_full  (i_tx_full),
        .o_wr_uart  (o_wr_uart),
        .o_w_data   (o_w_data),
        .o_result   (o_result),
        .o_op_err   (o_op_err)
    );

    always #5 i_clk = ~i_clk;

    // Reference ALU: shifts are done one bit at a time, capped at 8 steps.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        logic [7:0] r;
        logic       err;
        r   = 8'h00;
        err = 1'b0;
        case (op & 8'h3F)
            8'h20: r = a + b;
            8'h22: r = a - b;
            8'h24: r = a & b;
            8'h25: r = a | b;
            8'h26: r = a ^ b;
            8'h27: r = ~(a | b);
            8'h03: begin
                r = a;
                for (int i = 0; i < 8; i++) if (i < b) r = {r[7], r[7:1]};
            end
            8'h02: begin
                r = a;
                for (int i = 0; i < 8; i++) if (i < b) r = {1'b0, r[7:1]};
            end
            default: begin
                r   = 8'h00;
                err = 1'b1;
            end
        endcase
        return {err, r};
    endfunction

    always @(posedge i_clk) begin
        cycle++;
        if (o_rd_uart) begin
            pop_total++;
            pop_cycle.push_back(cycle);
            if (i_rx_empty) illegal_pop++;
        end
        if (o_wr_uart) begin
            push_cycle.push_back(cycle);
            obs_q.push_back({o_op_err, o_w_data});
            if (i_tx_full) illegal_push++;
        end
    end

    always @(negedge i_clk) begin
        rx_rd     = rx_rd + (pop_total - pops_seen);
        pops_seen = pop_total;
        if (fake_rx) begin
            i_rx_empty = 1'b0;
            i_r_data   = 8'hAA;
        end else if (rx_rd >= rx_q.size() || (gap_en && $urandom_range(0, 2) == 0)) begin
            i_rx_empty = 1'b1;
            i_r_data   = 8'($urandom);
        end else begin
            i_rx_empty = 1'b0;
            i_r_data   = rx_q[rx_rd];
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        exp_q.push_back(model(a, b, op));
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(op);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        fake_rx = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        checks++;
        if (o_rd_uart !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd: got %b, expected 0", o_rd_uart); end
        checks++;
        if (o_wr_uart !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr: got %b, expected 0", o_wr_uart); end
        checks++;
        if (o_result !== 8'h00 || o_w_data !== 8'h00) begin
            fails++; $display("[TB] FAIL reset_data: result=%h w_data=%h, expected 00", o_result, o_w_data);
        end
        checks++;
        if (o_op_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b, expected 0", o_op_err); end
        fake_rx = 1'b0;
        @(negedge i_clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        int pb, hb;
        logic [8:0] got, exp;
        pb = pop_cycle.size();
        hb = push_cycle.size();
        applyStimulus(8'h05, 8'h03, 8'h20);
        for (int t = 0; t < 200 && push_cycle.size() <= hb; t++) @(negedge i_clk);
        repeat (6) @(negedge i_clk);
        checks++;
        if (pop_cycle.size() - pb != 3) begin fails++; $display("[TB] FAIL b2b_pops: got %0d pops, expected 3", pop_cycle.size() - pb); end
        checks++;
        if (push_cycle.size() - hb != 1) begin fails++; $display("[TB] FAIL b2b_pushes: got %0d pushes, expected 1", push_cycle.size() - hb); end
        if (pop_cycle.size() - pb >= 3 && push_cycle.size() - hb >= 1) begin
            checks++;
            if (pop_cycle[pb+1] != pop_cycle[pb] + 1 || pop_cycle[pb+2] != pop_cycle[pb] + 2) begin
                fails++; $display("[TB] FAIL b2b_consecutive: pops at %0d %0d %0d, expected consecutive", pop_cycle[pb], pop_cycle[pb+1], pop_cycle[pb+2]);
            end
            checks++;
            if (push_cycle[hb] != pop_cycle[pb+2] + 2) begin
                fails++; $display("[TB] FAIL b2b_latency: push at %0d, expected %0d", push_cycle[hb], pop_cycle[pb+2] + 2);
            end
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("[TB] FAIL b2b_result: no push, expected %h", exp);
            end else begin
                got = obs_q[obs_rd];
                obs_rd++;
                if (got !== exp) begin fails++; $display("[TB] FAIL b2b_result: got %h, expected %h", got, exp); end
            end
        end
    endtask

    task automatic test_ops();
        logic [23:0] cmds [0:10];
        logic [8:0]  got, exp, last;
        int pb;
        cmds = '{24'h030522, 24'h800203, 24'h800902, 24'h0FF027, 24'hCCAA24, 24'hCCAA25,
                 24'hCCAA26, 24'h7F0303, 24'h90C803, 24'h40013F, 24'h1020E0};
        pb   = pop_cycle.size();
        last = model(cmds[10][23:16], cmds[10][15:8], cmds[10][7:0]);
        for (int i = 0; i < 11; i++) applyStimulus(cmds[i][23:16], cmds[i][15:8], cmds[i][7:0]);
        for (int t = 0; t < 1000 && obs_q.size() < obs_rd + exp_q.size(); t++) @(negedge i_clk);
        repeat (6) @(negedge i_clk);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("[TB] FAIL ops_result: no push, expected %h", exp);
            end else begin
                got = obs_q[obs_rd];
                obs_rd++;
                if (got !== exp) begin fails++; $display("[TB] FAIL ops_result: got %h, expected %h", got, exp); end
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin fails++; $display("[TB] FAIL ops_extra_push: %0d unexpected pushes", obs_q.size() - obs_rd); end
        checks++;
        if (pop_cycle.size() - pb < 4 || pop_cycle[pb+3] - pop_cycle[pb] != 5) begin
            fails++; $display("[TB] FAIL ops_turnaround: pops seen %0d, expected 5-cycle A-to-A spacing", pop_cycle.size() - pb);
        end
        checks++;
        if ({o_op_err, o_result} !== last) begin fails++; $display("[TB] FAIL ops_held: got %h, expected %h", {o_op_err, o_result}, last); end
    endtask

    task automatic test_tx_full();
        int pb, hb;
        logic [7:0] held;
        logic [8:0] got, exp;
        bit moved;
        pb = pop_cycle.size();
        hb = push_cycle.size();
        i_tx_full = 1'b1;
        applyStimulus(8'h12, 8'h34, 8'h26);
        for (int t = 0; t < 200 && pop_cycle.size() - pb < 3; t++) @(negedge i_clk);
        @(negedge i_clk);
        held  = o_w_data;
        moved = 1'b0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_w_data !== held) moved = 1'b1;
        end
        checks++;
        if (moved) begin fails++; $display("[TB] FAIL full_stable: w_data changed from %h to %h", held, o_w_data); end
        checks++;
        if (push_cycle.size() != hb) begin fails++; $display("[TB] FAIL full_no_push: got %0d pushes, expected 0", push_cycle.size() - hb); end
        checks++;
        if (held !== 8'h26) begin fails++; $display("[TB] FAIL full_held_value: got %h, expected 26", held); end
        i_tx_full = 1'b0;
        repeat (8) @(negedge i_clk);
        checks++;
        if (push_cycle.size() - hb != 1) begin fails++; $display("[TB] FAIL full_release: got %0d pushes, expected 1", push_cycle.size() - hb); end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("[TB] FAIL full_result: no push, expected %h", exp);
            end else begin
                got = obs_q[obs_rd];
                obs_rd++;
                if (got !== exp) begin fails++; $display("[TB] FAIL full_result: got %h, expected %h", got, exp); end
            end
        end
    endtask

    task automatic test_gaps();
        logic [8:0] got, exp;
        gap_en = 1'b1;
        applyStimulus(8'h05, 8'h03, 8'h20);
        applyStimulus(8'h03, 8'h05, 8'h22);
        applyStimulus(8'h90, 8'h04, 8'h03);
        for (int t = 0; t < 1000 && obs_q.size() < obs_rd + exp_q.size(); t++) @(negedge i_clk);
        gap_en = 1'b0;
        repeat (6) @(negedge i_clk);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("[TB] FAIL gaps_result: no push, expected %h", exp);
            end else begin
                got = obs_q[obs_rd];
                obs_rd++;
                if (got !== exp) begin fails++; $display("[TB] FAIL gaps_result: got %h, expected %h", got, exp); end
            end
        end
        checks++;
        if (illegal_pop != 0 || illegal_push != 0) begin
            fails++; $display("[TB] FAIL gaps_protocol: %0d pops while empty, %0d pushes while full, expected 0", illegal_pop, illegal_push);
        end
    endtask

    task automatic test_reset_mid();
        int pb;
        logic [8:0] got, exp;
        pb = pop_cycle.size();
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        for (int t = 0; t < 200 && pop_cycle.size() - pb < 2; t++) @(negedge i_clk);
        @(negedge i_clk);
        reset   = 1'b0;
        fake_rx = 1'b1;
        @(negedge i_clk);
        #1;
        checks++;
        if (o_result !== 8'h00 || o_w_data !== 8'h00 || o_op_err !== 1'b0) begin
            fails++; $display("[TB] FAIL mid_reset_values: result=%h w_data=%h err=%b, expected 00 00 0", o_result, o_w_data, o_op_err);
        end
        checks++;
        if (o_rd_uart !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_rd: got %b, expected 0", o_rd_uart); end
        fake_rx = 1'b0;
        @(negedge i_clk);
        #1 reset = 1'b1;
        applyStimulus(8'h01, 8'h01, 8'h20);
        for (int t = 0; t < 200 && obs_q.size() < obs_rd + exp_q.size(); t++) @(negedge i_clk);
        repeat (6) @(negedge i_clk);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                fails++; $display("[TB] FAIL mid_result: no push, expected %h", exp);
            end else begin
                got = obs_q[obs_rd];
                obs_rd++;
                if (got !== exp) begin fails++; $display("[TB] FAIL mid_result: got %h, expected %h", got, exp); end
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin fails++; $display("[TB] FAIL mid_extra_push: %0d unexpected pushes", obs_q.size() - obs_rd); end
    endtask

    initial begin
        #2;
        test_reset();
        test_back_to_back();
        test_ops();
        test_tx_full();
        test_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
